// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the ADS bus arbiter: state encoding, default size,
// master-index width derivation.
package ads_bus_pkg;

    localparam int unsigned DEFAULT_NUM_MASTERS = 2;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_BUSY       = 2'd1;
    localparam logic [1:0] ST_SPLIT_FREE = 2'd2;
    localparam logic [1:0] ST_SPLIT_BUSY = 2'd3;

    // Width of a master index, never narrower than one bit
    function automatic int unsigned midx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Arbitration bundle between the master ports and the central arbiter.
// slave: arbiter side; master: requester side (testbench / port logic).
interface bus_arbiter_if #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned MIDX_W      = 1
);
    logic [NUM_MASTERS-1:0] breq;
    logic [NUM_MASTERS-1:0] bgrant;
    logic [MIDX_W-1:0]      msel;
    logic                   bus_busy;
    logic                   split_req;
    logic                   split_done;
    logic [NUM_MASTERS-1:0] msplit;

    modport slave (
        input  breq, split_req, split_done,
        output bgrant, msel, bus_busy, msplit
    );

    modport master (
        output breq, split_req, split_done,
        input  bgrant, msel, bus_busy, msplit
    );
endinterface

// File: rtl/bus_arbiter_pick.sv
// Combinational winner selection for the arbiter.
// ARB_ROUND_ROBIN_EN defined: first requester strictly after ptr, wrapping.
// Otherwise: lowest requesting index wins and ptr is ignored.
module arb_pick #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned MIDX_W      = 1
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [MIDX_W-1:0]      ptr,
    output logic [MIDX_W-1:0]      win,
    output logic                   valid
);

`ifdef ARB_ROUND_ROBIN_EN
    // Scan from ptr+1 around the ring, first hit wins
    always_comb begin
        int unsigned idx;
        valid = 1'b0;
        win   = '0;
        idx   = 0;
        for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
            idx = (int unsigned'(ptr) + k) % NUM_MASTERS;
            if (!valid && req[idx]) begin
                valid = 1'b1;
                win   = idx[MIDX_W-1:0];
            end
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // Lowest set index wins
    always_comb begin
        valid = 1'b0;
        win   = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (!valid && req[i]) begin
                valid = 1'b1;
                win   = i[MIDX_W-1:0];
            end
        end
    end
`endif

endmodule

// File: rtl/bus_arbiter.sv
// ADS bus arbiter with split-transaction support. All outputs registered.
// Optional: ARB_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
module bus_arbiter
    import ads_bus_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = DEFAULT_NUM_MASTERS,
    parameter int unsigned MIDX_W      = midx_width(NUM_MASTERS)
) (
    input  logic          clk,
    input  logic          rst,
    bus_arbiter_if.slave  bus
);

    logic [1:0]             state_q,  state_d;
    logic [NUM_MASTERS-1:0] bgrant_q, bgrant_d;
    logic [NUM_MASTERS-1:0] msplit_q, msplit_d;
    logic [MIDX_W-1:0]      msel_q,   msel_d;
    logic                   busy_q,   busy_d;
    logic [MIDX_W-1:0]      sown_q,   sown_d;
    logic                   done_q,   done_d;
    logic [MIDX_W-1:0]      ptr_q;

    logic [NUM_MASTERS-1:0] elig;
    logic                   split_pend;
    logic                   owner_req;
    logic                   sown_req;
    logic [MIDX_W-1:0]      win;
    logic                   win_valid;

    function automatic logic [NUM_MASTERS-1:0] onehot(input logic [MIDX_W-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    // Requests visible to the picker exclude the suspended split owner
    always_comb begin
        split_pend = (state_q == ST_SPLIT_FREE) || (state_q == ST_SPLIT_BUSY);
        owner_req  = bus.breq[msel_q];
        sown_req   = bus.breq[sown_q];
        elig       = bus.breq & ~(split_pend ? onehot(sown_q) : '0);
    end

    arb_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .MIDX_W      (MIDX_W)
    ) u_pick (
        .req   (elig),
        .ptr   (ptr_q),
        .win   (win),
        .valid (win_valid)
    );

    // Arbitration and split state machine
    always_comb begin
        state_d  = state_q;
        bgrant_d = bgrant_q;
        msplit_d = msplit_q;
        msel_d   = msel_q;
        busy_d   = busy_q;
        sown_d   = sown_q;
        done_d   = done_q;
        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    bgrant_d = onehot(win);
                    msel_d   = win;
                    busy_d   = 1'b1;
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Release takes precedence over a coincident split_req
                if (!owner_req) begin
                    bgrant_d = '0;
                    busy_d   = 1'b0;
                    state_d  = ST_IDLE;
                end else if (bus.split_req) begin
                    sown_d   = msel_q;
                    msplit_d = onehot(msel_q);
                    bgrant_d = '0;
                    busy_d   = 1'b0;
                    done_d   = 1'b0;
                    state_d  = ST_SPLIT_FREE;
                end
            end
            ST_SPLIT_FREE: begin
                if (!sown_req) begin
                    msplit_d = '0;
                    done_d   = 1'b0;
                    state_d  = ST_IDLE;
                end else if (bus.split_done || done_q) begin
                    msplit_d = '0;
                    bgrant_d = onehot(sown_q);
                    msel_d   = sown_q;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    state_d  = ST_BUSY;
                end else if (win_valid) begin
                    bgrant_d = onehot(win);
                    msel_d   = win;
                    busy_d   = 1'b1;
                    state_d  = ST_SPLIT_BUSY;
                end
            end
            default: begin // ST_SPLIT_BUSY
                if (!sown_req) begin
                    // Abort keeps the current owner unless it also released
                    msplit_d = '0;
                    done_d   = 1'b0;
                    if (owner_req) begin
                        state_d = ST_BUSY;
                    end else begin
                        bgrant_d = '0;
                        busy_d   = 1'b0;
                        state_d  = ST_IDLE;
                    end
                end else if (!owner_req) begin
                    if (done_q || bus.split_done) begin
                        msplit_d = '0;
                        bgrant_d = onehot(sown_q);
                        msel_d   = sown_q;
                        done_d   = 1'b0;
                        state_d  = ST_BUSY;
                    end else begin
                        bgrant_d = '0;
                        busy_d   = 1'b0;
                        state_d  = ST_SPLIT_FREE;
                    end
                end else if (bus.split_done) begin
                    done_d = 1'b1;
                end
            end
        endcase
    end

`ifdef ARB_ROUND_ROBIN_EN
    logic [MIDX_W-1:0] ptr_d;

    // Pointer follows every fresh grant, split re-grants included
    always_comb begin
        ptr_d = ptr_q;
        if ((bgrant_d != '0) && (bgrant_d != bgrant_q)) begin
            ptr_d = msel_d;
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
`else
    assign ptr_q = '0;
`endif

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            bgrant_q <= '0;
            msplit_q <= '0;
            msel_q   <= '0;
            busy_q   <= 1'b0;
            sown_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bgrant_q <= bgrant_d;
            msplit_q <= msplit_d;
            msel_q   <= msel_d;
            busy_q   <= busy_d;
            sown_q   <= sown_d;
            done_q   <= done_d;
        end
    end

    assign bus.bgrant   = bgrant_q;
    assign bus.msplit   = msplit_q;
    assign bus.msel     = msel_q;
    assign bus.bus_busy = busy_q;

endmodule
